// File: rtl/hdmi_ovl_pkg.sv
// hdmi_ovl_pkg
// Shared constants and types for the HDMI text-label overlay.
//   - RGB565 colour constants (RED, BLUE, BLACK) and the opaque-box background colour.
//   - Glyph cell geometry (GLYPH_W x GLYPH_H).
//   - 6-bit character code type and the code points of each glyph group.
package hdmi_ovl_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;

    localparam logic [15:0] RED          = 16'hF800;
    localparam logic [15:0] BLUE         = 16'h001F;
    localparam logic [15:0] BLACK        = 16'h0000;
    localparam logic [15:0] OVL_BG_COLOR = BLUE;

    typedef logic [5:0] char_code_t;

    // Code map: space, digits '0'..'9', letters 'A'..'Z', then '-' and ':'.
    // Everything above CH_COLON renders as blank.
    localparam char_code_t CH_SPACE  = 6'd0;
    localparam char_code_t CH_DIGIT0 = 6'd1;
    localparam char_code_t CH_A      = 6'd11;
    localparam char_code_t CH_DASH   = 6'd37;
    localparam char_code_t CH_COLON  = 6'd38;

endpackage

// File: rtl/hdmi_font_rom.sv
// hdmi_font_rom
// Synchronous 8x16 font ROM, one cycle read latency.
// Ports:
//   hdmi_clk  in   pixel clock
//   sys_rst   in   synchronous active-high reset, clears the output register
//   addr      in   {char code[5:0], glyph row[3:0]}
//   data      out  glyph row, bit 7 is the leftmost pixel
module hdmi_font_rom
    import hdmi_ovl_pkg::*;
(
    input  logic       hdmi_clk,
    input  logic       sys_rst,
    input  logic [9:0] addr,
    output logic [7:0] data
);

    // Whole glyph per code, row 0 in the top byte.
    function automatic logic [127:0] glyph(input char_code_t code);
        case (code)
            6'd0:  glyph = 128'h0000_0000_0000_0000_0000_0000_0000_0000;
            6'd1:  glyph = 128'h0000_3C66_666E_7666_6666_663C_0000_0000;
            6'd2:  glyph = 128'h0000_1808_0808_0808_0808_0808_1C00_0000;
            6'd3:  glyph = 128'h0000_3C66_0606_0C18_3060_607E_0000_0000;
            6'd4:  glyph = 128'h0000_3C66_0606_1C06_0606_663C_0000_0000;
            6'd5:  glyph = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C0C_0000_0000;
            6'd6:  glyph = 128'h0000_7E60_607C_0606_0606_663C_0000_0000;
            6'd7:  glyph = 128'h0000_3C66_607C_6666_6666_663C_0000_0000;
            6'd8:  glyph = 128'h0000_7E06_060C_0C18_1830_3030_0000_0000;
            6'd9:  glyph = 128'h0000_3C66_6666_3C66_6666_663C_0000_0000;
            6'd10: glyph = 128'h0000_3C66_6666_3E06_0606_663C_0000_0000;
            6'd11: glyph = 128'h0000_183C_6666_667E_6666_6666_0000_0000;
            6'd12: glyph = 128'h0000_7C66_6666_7C66_6666_667C_0000_0000;
            6'd13: glyph = 128'h0000_3C66_6060_6060_6060_663C_0000_0000;
            6'd14: glyph = 128'h0000_786C_6666_6666_6666_6C78_0000_0000;
            6'd15: glyph = 128'h0000_7E60_6060_7C60_6060_607E_0000_0000;
            6'd16: glyph = 128'h0000_7E60_6060_7C60_6060_6060_0000_0000;
            6'd17: glyph = 128'h0000_3C66_6060_6E66_6666_663E_0000_0000;
            6'd18: glyph = 128'h0000_6666_6666_7E66_6666_6666_0000_0000;
            6'd19: glyph = 128'h0000_3C18_1818_1818_1818_183C_0000_0000;
            6'd20: glyph = 128'h0000_1E0C_0C0C_0C0C_0C6C_6C38_0000_0000;
            6'd21: glyph = 128'h0000_666C_7870_6070_786C_6666_0000_0000;
            6'd22: glyph = 128'h0000_6060_6060_6060_6060_607E_0000_0000;
            6'd23: glyph = 128'h0000_C6EE_FED6_C6C6_C6C6_C6C6_0000_0000;
            6'd24: glyph = 128'h0000_6666_7676_7E6E_6E66_6666_0000_0000;
            6'd25: glyph = 128'h0000_3C66_6666_6666_6666_663C_0000_0000;
            6'd26: glyph = 128'h0000_7C66_6666_7C60_6060_6060_0000_0000;
            6'd27: glyph = 128'h0000_3C66_6666_6666_666E_3C06_0000_0000;
            6'd28: glyph = 128'h0000_7C66_6666_7C78_6C66_6666_0000_0000;
            6'd29: glyph = 128'h0000_3C66_6030_180C_0606_663C_0000_0000;
            6'd30: glyph = 128'h0000_7E18_1818_1818_1818_1818_0000_0000;
            6'd31: glyph = 128'h0000_6666_6666_6666_6666_663C_0000_0000;
            6'd32: glyph = 128'h0000_6666_6666_6666_663C_3C18_0000_0000;
            6'd33: glyph = 128'h0000_C6C6_C6C6_C6D6_D6FE_EEC6_0000_0000;
            6'd34: glyph = 128'h0000_6666_3C3C_1818_3C3C_6666_0000_0000;
            6'd35: glyph = 128'h0000_6666_663C_1818_1818_1818_0000_0000;
            6'd36: glyph = 128'h0000_7E06_060C_1830_6060_607E_0000_0000;
            6'd37: glyph = 128'h0000_0000_0000_007E_0000_0000_0000_0000;
            6'd38: glyph = 128'h0000_0000_1818_0000_0018_1800_0000_0000;
            default: glyph = 128'h0;
        endcase
    endfunction

    logic [127:0] bitmap;

    // Look up the full glyph, then the registered stage below picks one row.
    always_comb begin
        bitmap = glyph(addr[9:4]);
    end

    // One-cycle registered read so the ROM maps onto a block memory.
    always_ff @(posedge hdmi_clk) begin
        if (sys_rst) begin
            data <= 8'h00;
        end else begin
            data <= bitmap[(4'd15 - addr[3:0])*8 +: 8];
        end
    end

endmodule

// File: rtl/hdmi_label_overlay.sv
// hdmi_label_overlay
// Keys one programmable text label per channel column over the framebuffer pixel stream.
// Three-stage pipeline: S1 region decode, S2 font ROM read, S3 bit select and colour mux.
// Ports:
//   hdmi_clk     in   pixel clock
//   sys_rst      in   synchronous active-high reset
//   pixel_xpos   in   current pixel x
//   pixel_ypos   in   current pixel y
//   pixel_vld    in   active-video qualifier
//   rd_data      in   framebuffer pixel
//   rd_h_pixel   in   active pixels per line
//   lbl_chars    in   char codes, channel c char k at [(c*MAX_CHARS+k)*6 +: 6]
//   lbl_color    in   glyph foreground colour
//   pixel_data   out  overlaid pixel, 3 cycles after input
//   pixel_vld_o  out  pixel_vld aligned with pixel_data
// Build option: define OVL_BG_EN to fill glyph-0 pixels of drawn labels with OVL_BG_COLOR.
module hdmi_label_overlay
    import hdmi_ovl_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int MAX_CHARS = 8,
    parameter int SCALE     = 1,
    parameter int Y_OFS     = 0,
    parameter int PIX_W     = 16,
    parameter int X_W       = 11
) (
    input  logic                      hdmi_clk,
    input  logic                      sys_rst,
    input  logic [X_W-1:0]            pixel_xpos,
    input  logic [X_W-1:0]            pixel_ypos,
    input  logic                      pixel_vld,
    input  logic [PIX_W-1:0]          rd_data,
    input  logic [12:0]               rd_h_pixel,
    input  logic [NUM_CH*MAX_CHARS*6-1:0] lbl_chars,
    input  logic [PIX_W-1:0]          lbl_color,
    output logic [PIX_W-1:0]          pixel_data,
    output logic                      pixel_vld_o
);

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W  = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
    localparam int CHR_W  = NUM_CH * MAX_CHARS * 6;
    localparam int CHR_IW = $clog2(CHR_W);
    localparam int LW     = MAX_CHARS * GLYPH_W * SCALE;
    localparam int BAND_H = GLYPH_H * SCALE;

`ifdef OVL_BG_EN
    localparam bit BG_EN = 1'b1;
`else
    localparam bit BG_EN = 1'b0;
`endif

    logic [CHR_W-1:0] shadow_chars;
    logic [PIX_W-1:0] shadow_color;

    logic [13:0] cw, lw14, x14, y14, dy, sel_dx, dx_s, dy_s;
    logic        label_fits, in_band, any_hit;
    logic [CH_W-1:0] sel_ch;
    logic [13:0] x0 [NUM_CH];
    logic [13:0] dx_full [NUM_CH];
    logic [NUM_CH-1:0] hit_c;

    // Frame-start latch: the render path only ever sees label settings captured at the
    // first valid pixel of a frame, so mid-frame writes cannot tear a label.
    always_ff @(posedge hdmi_clk) begin
        if (sys_rst) begin
            shadow_chars <= '0;
            shadow_color <= '0;
        end else if (pixel_vld && pixel_xpos == '0 && pixel_ypos == '0) begin
            shadow_chars <= lbl_chars;
            shadow_color <= lbl_color;
        end
    end

    assign cw         = 14'(rd_h_pixel >> $clog2(NUM_CH));
    assign lw14       = 14'(LW);
    assign x14        = 14'(pixel_xpos);
    assign y14        = 14'(pixel_ypos);
    // A label wider than its column is dropped; rd_h_pixel=0 also lands here since CW=0.
    assign label_fits = (cw >= lw14);
    assign in_band    = (y14 >= 14'(Y_OFS)) && (y14 < 14'(Y_OFS + BAND_H));
    assign dy         = y14 - 14'(Y_OFS);

    // Per-column label origin and box test, all in 14-bit unsigned arithmetic.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_col
        assign x0[c]      = 14'(c) * cw + (cw >> 1) - (lw14 >> 1);
        assign dx_full[c] = x14 - x0[c];
        assign hit_c[c]   = label_fits && (x14 >= x0[c]) && (dx_full[c] < lw14);
    end

    // Walk columns from the top down so the lowest-numbered hit is the one kept.
    always_comb begin
        any_hit = 1'b0;
        sel_ch  = '0;
        sel_dx  = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (hit_c[c]) begin
                any_hit = 1'b1;
                sel_ch  = CH_W'(c);
                sel_dx  = dx_full[c];
            end
        end
    end

    assign dx_s = sel_dx >> $clog2(SCALE);
    assign dy_s = dy >> $clog2(SCALE);

    logic                 s1_hit, s1_vld;
    logic [CH_W-1:0]      s1_ch;
    logic [IDX_W-1:0]     s1_idx;
    logic [2:0]           s1_col;
    logic [3:0]           s1_row;
    logic [PIX_W-1:0]     s1_data;

    // S1: register the decoded label coordinates alongside the raw pixel.
    always_ff @(posedge hdmi_clk) begin
        if (sys_rst) begin
            s1_hit  <= 1'b0;
            s1_vld  <= 1'b0;
            s1_ch   <= '0;
            s1_idx  <= '0;
            s1_col  <= '0;
            s1_row  <= '0;
            s1_data <= '0;
        end else begin
            s1_hit  <= any_hit && in_band && pixel_vld;
            s1_vld  <= pixel_vld;
            s1_ch   <= sel_ch;
            s1_idx  <= IDX_W'(dx_s >> 3);
            s1_col  <= dx_s[2:0];
            s1_row  <= dy_s[3:0];
            s1_data <= rd_data;
        end
    end

    logic [CHR_IW-1:0] code_base;
    char_code_t        s1_code;
    logic [7:0]        rom_data;

    assign code_base = CHR_IW'((int'(s1_ch) * MAX_CHARS + int'(s1_idx)) * 6);
    assign s1_code   = shadow_chars[code_base +: 6];

    hdmi_font_rom u_font_rom (
        .hdmi_clk (hdmi_clk),
        .sys_rst  (sys_rst),
        .addr     ({s1_code, s1_row}),
        .data     (rom_data)
    );

    logic             s2_hit, s2_vld;
    logic [2:0]       s2_col;
    logic [PIX_W-1:0] s2_data;

    // S2: carry the side-band alongside the ROM read so it lines up with rom_data.
    always_ff @(posedge hdmi_clk) begin
        if (sys_rst) begin
            s2_hit  <= 1'b0;
            s2_vld  <= 1'b0;
            s2_col  <= '0;
            s2_data <= '0;
        end else begin
            s2_hit  <= s1_hit;
            s2_vld  <= s1_vld;
            s2_col  <= s1_col;
            s2_data <= s1_data;
        end
    end

    logic glyph_bit;
    assign glyph_bit = rom_data[3'd7 - s2_col];

    // S3: foreground on a set glyph bit, optional opaque box, otherwise pass-through.
    always_ff @(posedge hdmi_clk) begin
        if (sys_rst) begin
            pixel_data  <= '0;
            pixel_vld_o <= 1'b0;
        end else begin
            pixel_vld_o <= s2_vld;
            if (s2_hit && glyph_bit) begin
                pixel_data <= shadow_color;
            end else if (s2_hit && BG_EN) begin
                pixel_data <= PIX_W'(OVL_BG_COLOR);
            end else begin
                pixel_data <= s2_data;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_label_overlay.sv
// tb_hdmi_label_overlay
// Directed checks of the label overlay: main instance (2 columns, scale 1), a scale-2
// instance and a 4-column instance whose labels are too wide for their columns.
// Honours OVL_BG_EN the same way as the design.
module tb_hdmi_label_overlay;

    logic         hdmi_clk = 1'b0;
    logic         sys_rst;
    logic [10:0]  pixel_xpos, pixel_ypos;
    logic         pixel_vld;
    logic [15:0]  rd_data;
    logic [12:0]  rd_h_pixel, rd_h_pixel_c4;
    logic [95:0]  lbl_chars, lbl_chars_s2;
    logic [191:0] lbl_chars_c4;
    logic [15:0]  lbl_color;
    logic [15:0]  pixel_data, pd_s2, pd_c4;
    logic         pixel_vld_o, vo_s2, vo_c4;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [15:0] C_RED  = 16'hF800;
    localparam logic [15:0] C_BLUE = 16'h001F;

    // Rows of the '1' glyph (code 2); every other code used here is blank.
    logic [7:0] one_glyph [16] = '{8'h00, 8'h00, 8'h18, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08,
                                   8'h08, 8'h08, 8'h08, 8'h08, 8'h1C, 8'h00, 8'h00, 8'h00};
    logic [95:0] m_chars;

    always #5 hdmi_clk = ~hdmi_clk;

    hdmi_label_overlay #(.NUM_CH(2), .MAX_CHARS(8), .SCALE(1), .Y_OFS(0), .PIX_W(16), .X_W(11)) dut (
        .hdmi_clk(hdmi_clk), .sys_rst(sys_rst), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
        .pixel_vld(pixel_vld), .rd_data(rd_data), .rd_h_pixel(rd_h_pixel), .lbl_chars(lbl_chars),
        .lbl_color(lbl_color), .pixel_data(pixel_data), .pixel_vld_o(pixel_vld_o));

    hdmi_label_overlay #(.NUM_CH(2), .MAX_CHARS(8), .SCALE(2), .Y_OFS(0), .PIX_W(16), .X_W(11)) dut_s2 (
        .hdmi_clk(hdmi_clk), .sys_rst(sys_rst), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
        .pixel_vld(pixel_vld), .rd_data(rd_data), .rd_h_pixel(rd_h_pixel), .lbl_chars(lbl_chars_s2),
        .lbl_color(lbl_color), .pixel_data(pd_s2), .pixel_vld_o(vo_s2));

    hdmi_label_overlay #(.NUM_CH(4), .MAX_CHARS(8), .SCALE(2), .Y_OFS(0), .PIX_W(16), .X_W(11)) dut_c4 (
        .hdmi_clk(hdmi_clk), .sys_rst(sys_rst), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
        .pixel_vld(pixel_vld), .rd_data(rd_data), .rd_h_pixel(rd_h_pixel_c4), .lbl_chars(lbl_chars_c4),
        .lbl_color(lbl_color), .pixel_data(pd_c4), .pixel_vld_o(vo_c4));

    // Inside a drawn label box, glyph-0 pixels are either transparent or the box colour.
    function automatic logic [15:0] box_bg(input logic [15:0] d);
`ifdef OVL_BG_EN
        return C_BLUE;
`else
        return d;
`endif
    endfunction

    function automatic logic [95:0] set_char(input logic [95:0] v, input int ch, input int k,
                                             input logic [5:0] code);
        logic [95:0] r;
        r = v;
        r[(ch*8+k)*6 +: 6] = code;
        return r;
    endfunction

    // Reference: 2 columns of 640, label origins at 288 and 928, 64 wide, 16 tall.
    function automatic logic [15:0] model_pix(input int x, input int y, input logic v,
                                              input logic [15:0] d);
        logic [15:0] r;
        r = d;
        if (v && y < 16) begin
            for (int c = 0; c < 2; c++) begin
                int x0;
                int dx;
                logic [5:0] code;
                logic [7:0] row;
                x0 = c*640 + 320 - 32;
                if (x >= x0 && x < x0 + 64) begin
                    dx = x - x0;
                    code = m_chars[(c*8 + dx/8)*6 +: 6];
                    row = (code == 6'd2) ? one_glyph[y] : 8'h00;
                    r = row[7 - (dx % 8)] ? lbl_color : box_bg(d);
                end
            end
        end
        return r;
    endfunction

    // Present one pixel and wait out the 3-cycle latency.
    task automatic put_pixel(input int x, input int y, input logic v, input logic [15:0] d);
        pixel_xpos = 11'(x);
        pixel_ypos = 11'(y);
        pixel_vld  = v;
        rd_data    = d;
        repeat (3) @(posedge hdmi_clk);
        #1;
    endtask

    task automatic frame_start();
        put_pixel(0, 0, 1'b1, 16'h0000);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        pixel_xpos = '0; pixel_ypos = '0; pixel_vld = 1'b1; rd_data = 16'hFFFF;
        rd_h_pixel = 13'd1280; rd_h_pixel_c4 = 13'd200;
        lbl_chars = '0; lbl_chars_s2 = '0; lbl_chars_c4 = '0; lbl_color = C_RED;
        repeat (3) @(posedge hdmi_clk);
        #1;
        vectors++;
        if (pixel_data !== 16'h0000) begin
            miscompares++; $display("[TB] FAIL reset_data: got %h expected 0000", pixel_data);
        end
        vectors++;
        if (pixel_vld_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_vld: got %b expected 0", pixel_vld_o);
        end
        vectors++;
        if (pd_s2 !== 16'h0000 || vo_c4 !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_others: got %h/%b expected 0000/0", pd_s2, vo_c4);
        end
        sys_rst = 1'b0;
    endtask

    task automatic test_glyph();
        lbl_chars = set_char('0, 0, 0, 6'd2);
        frame_start();
        put_pixel(292, 3, 1'b1, 16'h1234);
        vectors++;
        if (pixel_data !== C_RED || pixel_vld_o !== 1'b1) begin
            miscompares++; $display("[TB] FAIL glyph_set: got %h/%b expected %h/1", pixel_data, pixel_vld_o, C_RED);
        end
        put_pixel(291, 3, 1'b1, 16'h5678);
        vectors++;
        if (pixel_data !== box_bg(16'h5678)) begin
            miscompares++; $display("[TB] FAIL glyph_clear: got %h expected %h", pixel_data, box_bg(16'h5678));
        end
        put_pixel(287, 3, 1'b1, 16'h0F0F);
        vectors++;
        if (pixel_data !== 16'h0F0F) begin
            miscompares++; $display("[TB] FAIL left_of_box: got %h expected 0f0f", pixel_data);
        end
        put_pixel(292, 12, 1'b1, 16'h1111);
        vectors++;
        if (pixel_data !== C_RED) begin
            miscompares++; $display("[TB] FAIL glyph_row12: got %h expected %h", pixel_data, C_RED);
        end
        put_pixel(292, 16, 1'b1, 16'h2222);
        vectors++;
        if (pixel_data !== 16'h2222) begin
            miscompares++; $display("[TB] FAIL below_band: got %h expected 2222", pixel_data);
        end
        put_pixel(292, 3, 1'b0, 16'hAAAA);
        vectors++;
        if (pixel_data !== 16'hAAAA || pixel_vld_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL invalid_pixel: got %h/%b expected aaaa/0", pixel_data, pixel_vld_o);
        end
        rd_h_pixel = 13'd0;
        put_pixel(292, 3, 1'b1, 16'h3333);
        vectors++;
        if (pixel_data !== 16'h3333) begin
            miscompares++; $display("[TB] FAIL zero_width: got %h expected 3333", pixel_data);
        end
        rd_h_pixel = 13'd1280;
    endtask

    task automatic test_second_column();
        logic [15:0] d;
        for (int y = 0; y < 16; y++) begin
            for (int x = 928; x < 992; x++) begin
                d = 16'(x * 7 + y);
                put_pixel(x, y, 1'b1, d);
                vectors++;
                if (pixel_data !== box_bg(d)) begin
                    miscompares++;
                    $display("[TB] FAIL blank_ch1 (%0d,%0d): got %h expected %h", x, y, pixel_data, box_bg(d));
                end
            end
        end
        lbl_chars = set_char(lbl_chars, 1, 7, 6'd2);
        frame_start();
        put_pixel(988, 3, 1'b1, 16'h4444);
        vectors++;
        if (pixel_data !== C_RED) begin
            miscompares++; $display("[TB] FAIL ch1_char7: got %h expected %h", pixel_data, C_RED);
        end
        put_pixel(987, 3, 1'b1, 16'h4545);
        vectors++;
        if (pixel_data !== box_bg(16'h4545)) begin
            miscompares++; $display("[TB] FAIL ch1_char7_clear: got %h expected %h", pixel_data, box_bg(16'h4545));
        end
    endtask

    task automatic test_frame_latch();
        logic [95:0] saved;
        saved = lbl_chars;
        put_pixel(292, 4, 1'b1, 16'h0101);
        lbl_chars = '0;
        put_pixel(292, 5, 1'b1, 16'h0505);
        vectors++;
        if (pixel_data !== C_RED) begin
            miscompares++; $display("[TB] FAIL latch_row5: got %h expected %h", pixel_data, C_RED);
        end
        put_pixel(988, 9, 1'b1, 16'h0909);
        vectors++;
        if (pixel_data !== C_RED) begin
            miscompares++; $display("[TB] FAIL latch_ch1_row9: got %h expected %h", pixel_data, C_RED);
        end
        put_pixel(292, 12, 1'b1, 16'h0C0C);
        vectors++;
        if (pixel_data !== C_RED) begin
            miscompares++; $display("[TB] FAIL latch_row12: got %h expected %h", pixel_data, C_RED);
        end
        frame_start();
        put_pixel(292, 5, 1'b1, 16'h5A5A);
        vectors++;
        if (pixel_data !== box_bg(16'h5A5A)) begin
            miscompares++; $display("[TB] FAIL latch_new_label: got %h expected %h", pixel_data, box_bg(16'h5A5A));
        end
        lbl_chars = saved;
        frame_start();
    endtask

    task automatic test_scale_clip();
        int xs2 [6] = '{296, 297, 296, 297, 294, 298};
        int ys2 [6] = '{6, 6, 7, 7, 6, 7};
        logic [15:0] d;
        logic [15:0] e;
        for (int i = 0; i < 6; i++) begin
            d = 16'(16'h6000 + i);
            put_pixel(xs2[i], ys2[i], 1'b1, d);
            e = (i < 4) ? C_RED : box_bg(d);
            vectors++;
            if (pd_s2 !== e) begin
                miscompares++;
                $display("[TB] FAIL scale2 (%0d,%0d): got %h expected %h", xs2[i], ys2[i], pd_s2, e);
            end
        end
        put_pixel(296, 32, 1'b1, 16'h6F6F);
        vectors++;
        if (pd_s2 !== 16'h6F6F) begin
            miscompares++; $display("[TB] FAIL scale2_below_band: got %h expected 6f6f", pd_s2);
        end
        for (int x = 5; x < 200; x += 15) begin
            d = 16'(16'h7000 + x);
            put_pixel(x, 6, 1'b1, d);
            vectors++;
            if (pd_c4 !== d || vo_c4 !== 1'b1) begin
                miscompares++; $display("[TB] FAIL clip_c4 x=%0d: got %h expected %h", x, pd_c4, d);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        put_pixel(292, 8, 1'b1, 16'h3C3C);
        vectors++;
        if (pixel_data !== C_RED) begin
            miscompares++; $display("[TB] FAIL pre_reset: got %h expected %h", pixel_data, C_RED);
        end
        sys_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge hdmi_clk);
            #1;
            vectors++;
            if (pixel_data !== 16'h0000 || pixel_vld_o !== 1'b0) begin
                miscompares++; $display("[TB] FAIL in_reset %0d: got %h/%b expected 0000/0", i, pixel_data, pixel_vld_o);
            end
        end
        sys_rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge hdmi_clk);
            #1;
            vectors++;
            if (pixel_data !== 16'h0000 || pixel_vld_o !== 1'b0) begin
                miscompares++; $display("[TB] FAIL post_reset_fill %0d: got %h/%b expected 0000/0", i, pixel_data, pixel_vld_o);
            end
        end
        @(posedge hdmi_clk);
        #1;
        vectors++;
        if (pixel_data !== box_bg(16'h3C3C) || pixel_vld_o !== 1'b1) begin
            miscompares++; $display("[TB] FAIL post_reset_pass: got %h/%b expected %h/1", pixel_data, pixel_vld_o, box_bg(16'h3C3C));
        end
        frame_start();
        put_pixel(292, 8, 1'b1, 16'h3D3D);
        vectors++;
        if (pixel_data !== C_RED) begin
            miscompares++; $display("[TB] FAIL relabel_after_reset: got %h expected %h", pixel_data, C_RED);
        end
    endtask

    task automatic test_random_stream();
        logic [15:0] expd [$];
        logic        expv [$];
        logic [5:0]  codes [3] = '{6'd0, 6'd2, 6'd45};
        logic [95:0] nc;
        logic [15:0] ed;
        logic        ev;
        int x, y;
        logic v;
        m_chars = '0;
        for (int i = 0; i < 402; i++) begin
            if (i < 400) begin
                if ($urandom_range(0, 49) == 0) begin
                    for (int k = 0; k < 16; k++) nc[k*6 +: 6] = codes[$urandom_range(0, 2)];
                    lbl_chars = nc;
                end
                if ($urandom_range(0, 39) == 0) begin
                    x = 0; y = 0; v = 1'b1;
                end else begin
                    x = ($urandom_range(0, 1) == 1) ? int'($urandom_range(280, 360)) : int'($urandom_range(920, 1000));
                    y = int'($urandom_range(0, 20));
                    v = ($urandom_range(0, 3) != 0);
                end
            end else begin
                x = 2000; y = 100; v = 1'b0;
            end
            pixel_xpos = 11'(x); pixel_ypos = 11'(y); pixel_vld = v;
            rd_data = 16'($urandom);
            if (v && x == 0 && y == 0) m_chars = lbl_chars;
            expd.push_back(model_pix(x, y, v, rd_data));
            expv.push_back(v);
            @(posedge hdmi_clk);
            #1;
            if (i >= 2) begin
                ed = expd.pop_front();
                ev = expv.pop_front();
                vectors++;
                if (pixel_data !== ed || pixel_vld_o !== ev) begin
                    miscompares++;
                    $display("[TB] FAIL stream %0d: got %h/%b expected %h/%b", i - 2, pixel_data, pixel_vld_o, ed, ev);
                end
            end
        end
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        lbl_chars_s2 = '0;
        test_reset();
        lbl_chars_s2 = set_char('0, 0, 2, 6'd2);
        for (int k = 0; k < 32; k++) lbl_chars_c4[k*6 +: 6] = 6'd2;
        test_glyph();
        test_second_column();
        test_frame_latch();
        test_scale_clip();
        test_reset_mid_frame();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
